// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the 3-stage RISC-V core.
// Holds opcode and funct3 constants, memory region codes, the writeback
// select enum and small decode helpers used by the memory/writeback stage.
package riscv_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Region codes on address bits [31:28]
    localparam logic [3:0] REGION_DMEM = 4'b0001;
    localparam logic [3:0] REGION_IMEM = 4'b0010;
    localparam logic [3:0] REGION_BOTH = 4'b0011;
    localparam logic [3:0] REGION_BIOS = 4'b0100;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    // Coarse instruction class carried into MW. Branches and unknown
    // opcodes fold into CLS_NONE since neither writes the register file.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JUMP
    } op_class_e;

    // Source of load data, resolved in X and registered for MW.
    typedef enum logic [1:0] {
        LSRC_NONE,
        LSRC_DMEM,
        LSRC_BIOS
    } load_src_e;

    function automatic op_class_e decode_class(input logic [6:0] opcode);
        op_class_e cls;
        case (opcode)
            OPC_OP:               cls = CLS_R;
            OPC_OP_IMM:           cls = CLS_IALU;
            OPC_LOAD:             cls = CLS_LOAD;
            OPC_STORE:            cls = CLS_STORE;
            OPC_LUI:              cls = CLS_LUI;
            OPC_AUIPC:            cls = CLS_AUIPC;
            OPC_JAL, OPC_JALR:    cls = CLS_JUMP;
            default:              cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic wb_sel_e wb_sel_of(input op_class_e cls);
        wb_sel_e sel;
        case (cls)
            CLS_LOAD: sel = WB_MEM;
            CLS_JUMP: sel = WB_PC4;
            default:  sel = WB_ALU;
        endcase
        return sel;
    endfunction

    function automatic logic writes_rd(input op_class_e cls);
        return (cls != CLS_NONE) && (cls != CLS_STORE);
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: aligns a 32-bit memory word for a load and extends it.
// Ports:
//   data   - raw 32-bit word returned by memory
//   off    - byte offset within the word (address bits [1:0])
//   funct3 - load type (LB, LH, LW, LBU, LHU)
//   value  - shifted and sign/zero-extended result
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = data >> {off, 3'b000};
        value   = shifted;
        case (funct3)
            F3_LB:   value = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   value = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   value = shifted;
            F3_LBU:  value = {24'h0, shifted[7:0]};
            F3_LHU:  value = {16'h0, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage of the 3-stage RISC-V core.
// Drives byte-masked stores to IMEM port a and DMEM from the X stage,
// issues load reads to DMEM/BIOS, and one cycle later formats the returned
// data into the register-file writeback.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stall               - hold MW registers and suppress writes
//   valid_x, inst_x     - X-stage instruction and its valid flag
//   pc_x, alu_x, rs2_x  - X-stage PC, ALU result (address), store data
//   imem_*              - IMEM port a (write side)
//   dmem_*              - DMEM read/write port
//   bios_addrb/doutb    - BIOS port b (read side)
//   rf_we, rf_wa, wb_val- register-file writeback (MW)
//   misaligned          - one-cycle MW pulse for a suppressed access
//
// Build option: define IMEM_WRITE_GUARD_EN to allow IMEM writes only while
// executing from BIOS (pc_x[30] set); blocked writes report through
// misaligned as an access fault.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned IMEM_AW = 14,
    parameter int unsigned BIOS_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               valid_x,
    input  logic [31:0]        inst_x,
    input  logic [31:0]        pc_x,
    input  logic [31:0]        alu_x,
    input  logic [31:0]        rs2_x,
    output logic               imem_ena,
    output logic [3:0]         imem_wea,
    output logic [IMEM_AW-1:0] imem_addra,
    output logic [31:0]        imem_dina,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [IMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic [BIOS_AW-1:0] bios_addrb,
    input  logic [31:0]        bios_doutb,
    output logic               rf_we,
    output logic [4:0]         rf_wa,
    output logic [31:0]        wb_val,
    output logic               misaligned
);

    // ------------------------------------------------------------------
    // X stage decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_x;
    logic [1:0]  off_x;
    logic [3:0]  region;
    op_class_e   cls_x;
    logic        hit_dmem;
    logic        hit_imem;
    logic        mis_x;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic        write_ok;
    logic        imem_allowed;
    logic        guard_fault;
    logic        fault_x;
    load_src_e   lsrc_x;

    assign opcode = inst_x[6:0];
    assign funct3 = inst_x[14:12];
    assign rd_x   = inst_x[11:7];
    assign off_x  = alu_x[1:0];
    assign region = alu_x[31:28];
    assign cls_x  = decode_class(opcode);

    assign hit_dmem = (region == REGION_DMEM) || (region == REGION_BOTH);
    assign hit_imem = (region == REGION_IMEM) || (region == REGION_BOTH);

    always_comb begin
        mis_x = 1'b0;
        if (cls_x == CLS_STORE) begin
            case (funct3)
                F3_SH:   mis_x = off_x[0];
                F3_SW:   mis_x = (off_x != 2'b00);
                default: mis_x = 1'b0;
            endcase
        end else if (cls_x == CLS_LOAD) begin
            case (funct3)
                F3_LH, F3_LHU: mis_x = off_x[0];
                F3_LW:         mis_x = (off_x != 2'b00);
                default:       mis_x = 1'b0;
            endcase
        end
    end

    always_comb begin
        st_mask = 4'b0000;
        st_data = rs2_x;
        case (funct3)
            F3_SB: begin
                st_mask = 4'b0001 << off_x;
                st_data = {4{rs2_x[7:0]}};
            end
            F3_SH: begin
                st_mask = 4'b0011 << off_x;
                st_data = {2{rs2_x[15:0]}};
            end
            F3_SW: begin
                st_mask = 4'b1111;
                st_data = rs2_x;
            end
            default: begin
                st_mask = 4'b0000;
                st_data = rs2_x;
            end
        endcase
    end

`ifdef IMEM_WRITE_GUARD_EN
    // Only code running from BIOS may rewrite instruction memory.
    assign imem_allowed = pc_x[30];
`else
    assign imem_allowed = 1'b1;
`endif

    // Rst is included so a store sitting in X during reset never commits.
    assign write_ok = valid_x && !stall && !rst && (cls_x == CLS_STORE) && !mis_x;

    assign guard_fault = valid_x && (cls_x == CLS_STORE) && !mis_x && hit_imem &&
                         !imem_allowed;

    assign fault_x = valid_x && ((((cls_x == CLS_LOAD) || (cls_x == CLS_STORE)) && mis_x) ||
                                 guard_fault);

    always_comb begin
        lsrc_x = LSRC_NONE;
        if (hit_dmem) begin
            lsrc_x = LSRC_DMEM;
        end else if (region == REGION_BIOS) begin
            lsrc_x = LSRC_BIOS;
        end
    end

    // ------------------------------------------------------------------
    // Memory ports
    // ------------------------------------------------------------------
    assign imem_ena   = 1'b1;
    assign dmem_en    = 1'b1;
    assign imem_addra = alu_x[IMEM_AW+1:2];
    assign dmem_addr  = alu_x[IMEM_AW+1:2];
    assign bios_addrb = alu_x[BIOS_AW+1:2];
    assign imem_dina  = st_data;
    assign dmem_din   = st_data;
    assign dmem_we    = (write_ok && hit_dmem) ? st_mask : 4'b0000;
    assign imem_wea   = (write_ok && hit_imem && imem_allowed) ? st_mask : 4'b0000;

    // ------------------------------------------------------------------
    // MW pipeline registers
    // ------------------------------------------------------------------
    logic        valid_mw;
    logic [4:0]  rd_mw;
    op_class_e   cls_mw;
    logic [2:0]  funct3_mw;
    logic [1:0]  off_mw;
    load_src_e   lsrc_mw;
    logic [31:0] pc_mw;
    logic [31:0] alu_mw;
    logic        mis_mw;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_mw  <= 1'b0;
            rd_mw     <= 5'd0;
            cls_mw    <= CLS_NONE;
            funct3_mw <= 3'd0;
            off_mw    <= 2'd0;
            lsrc_mw   <= LSRC_NONE;
            pc_mw     <= 32'd0;
            alu_mw    <= 32'd0;
            mis_mw    <= 1'b0;
        end else if (!stall) begin
            valid_mw  <= valid_x;
            rd_mw     <= rd_x;
            cls_mw    <= cls_x;
            funct3_mw <= funct3;
            off_mw    <= off_x;
            lsrc_mw   <= lsrc_x;
            pc_mw     <= pc_x;
            alu_mw    <= alu_x;
            mis_mw    <= fault_x;
        end
    end

    // ------------------------------------------------------------------
    // Writeback
    // ------------------------------------------------------------------
    logic [31:0] load_raw;
    logic [31:0] load_val;

    always_comb begin
        case (lsrc_mw)
            LSRC_DMEM: load_raw = dmem_dout;
            LSRC_BIOS: load_raw = bios_doutb;
            default:   load_raw = 32'd0;
        endcase
    end

    load_extend u_load_extend (
        .data   (load_raw),
        .off    (off_mw),
        .funct3 (funct3_mw),
        .value  (load_val)
    );

    always_comb begin
        case (wb_sel_of(cls_mw))
            WB_MEM:  wb_val = mis_mw ? 32'd0 : load_val;
            WB_PC4:  wb_val = pc_mw + 32'd4;
            default: wb_val = alu_mw;
        endcase
    end

    assign rf_wa      = rd_mw;
    assign rf_we      = valid_mw && (rd_mw != 5'd0) && writes_rd(cls_mw) && !stall;
    assign misaligned = mis_mw && !stall;

    // Immediate/rs fields are consumed by earlier stages, not here.
    logic unused_inst;
    assign unused_inst = ^inst_x[31:15];

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// Inputs change 1 time unit after each rising edge; outputs are sampled
// before the following edge.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        valid_x;
    logic [31:0] inst_x;
    logic [31:0] pc_x;
    logic [31:0] alu_x;
    logic [31:0] rs2_x;
    logic        imem_ena;
    logic [3:0]  imem_wea;
    logic [13:0] imem_addra;
    logic [31:0] imem_dina;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;
    logic [11:0] bios_addrb;
    logic [31:0] bios_doutb;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] wb_val;
    logic        misaligned;

    int n_pass;
    int n_total;

    mem_wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .valid_x    (valid_x),
        .inst_x     (inst_x),
        .pc_x       (pc_x),
        .alu_x      (alu_x),
        .rs2_x      (rs2_x),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_dout  (dmem_dout),
        .bios_addrb (bios_addrb),
        .bios_doutb (bios_doutb),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .wb_val     (wb_val),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_store(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
    endfunction

    function automatic logic [31:0] mk_load(input logic [2:0] f3, input logic [4:0] rd);
        return {12'd0, 5'd1, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] mk_jal(input logic [4:0] rd);
        return {20'd0, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] mk_addi(input logic [4:0] rd);
        return {12'd0, 5'd1, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rs2);
        valid_x = v;
        inst_x  = inst;
        pc_x    = pc;
        alu_x   = alu;
        rs2_x   = rs2;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        dmem_dout  = 32'd0;
        bios_doutb = 32'd0;
        set_x(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();

        // Reset state
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
        check("rst_wb_val", wb_val, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("enables", {30'd0, imem_ena, dmem_en}, 32'd3);

        // Store presented while reset is still high must not write
        set_x(1'b1, mk_store(3'b010), 32'd0, 32'h1000_0010, 32'hDEAD_BEEF);
        check("rst_store_dmem_we", {28'd0, dmem_we}, 32'd0);
        check("rst_store_imem_wea", {28'd0, imem_wea}, 32'd0);
        tick();
        rst = 1'b0;
        #1;

        // SW to DMEM
        check("sw_dmem_we", {28'd0, dmem_we}, 32'hF);
        check("sw_dmem_addr", {18'd0, dmem_addr}, 32'd4);
        check("sw_dmem_din", dmem_din, 32'hDEAD_BEEF);
        check("sw_imem_wea", {28'd0, imem_wea}, 32'd0);

        // SB to the shared region, byte 3
        tick();
        set_x(1'b1, mk_store(3'b000), 32'd0, 32'h3000_0007, 32'h0000_00AB);
        check("sw_mw_rf_we", {31'd0, rf_we}, 32'd0);
        check("sb_dmem_we", {28'd0, dmem_we}, 32'h8);
        check("sb_imem_wea", {28'd0, imem_wea}, 32'h8);
        check("sb_dmem_din", dmem_din, 32'hABAB_ABAB);
        check("sb_imem_dina", imem_dina, 32'hABAB_ABAB);
        check("sb_imem_addra", {18'd0, imem_addra}, 32'd1);

        // LB then LBU at byte 3 of DMEM word 0
        tick();
        set_x(1'b1, mk_load(3'b000, 5'd5), 32'd0, 32'h1000_0003, 32'd0);
        check("lb_dmem_addr", {18'd0, dmem_addr}, 32'd0);
        check("lb_no_write", {28'd0, dmem_we}, 32'd0);
        tick();
        dmem_dout = 32'h80FF_FF7F;
        set_x(1'b1, mk_load(3'b100, 5'd6), 32'd0, 32'h1000_0003, 32'd0);
        check("lb_wb_val", wb_val, 32'hFFFF_FF80);
        check("lb_rf_we", {31'd0, rf_we}, 32'd1);
        check("lb_rf_wa", {27'd0, rf_wa}, 32'd5);

        // LW from BIOS word 2
        tick();
        set_x(1'b1, mk_load(3'b010, 5'd7), 32'd0, 32'h4000_0008, 32'd0);
        check("lbu_wb_val", wb_val, 32'h0000_0080);
        check("lw_bios_addrb", {20'd0, bios_addrb}, 32'd2);
        tick();
        bios_doutb = 32'h1234_5678;
        dmem_dout  = 32'hCAFE_F00D;
        set_x(1'b1, mk_store(3'b001), 32'd0, 32'h1000_0001, 32'h0000_1234);
        check("lw_bios_wb_val", wb_val, 32'h1234_5678);
        check("lw_bios_rf_wa", {27'd0, rf_wa}, 32'd7);
        check("lw_no_fault", {31'd0, misaligned}, 32'd0);
        check("sh_mis_dmem_we", {28'd0, dmem_we}, 32'd0);

        // Misaligned SH reaches MW
        tick();
        set_x(1'b1, mk_jal(5'd1), 32'h0000_0100, 32'd0, 32'd0);
        check("sh_mis_pulse", {31'd0, misaligned}, 32'd1);
        check("sh_rf_we", {31'd0, rf_we}, 32'd0);

        // JAL rd=x1
        tick();
        check("jal_pulse_gone", {31'd0, misaligned}, 32'd0);
        check("jal_wb_val", wb_val, 32'h0000_0104);
        check("jal_rf_we", {31'd0, rf_we}, 32'd1);
        check("jal_rf_wa", {27'd0, rf_wa}, 32'd1);

        // One-cycle stall: no write-back, no store, outputs held
        stall = 1'b1;
        set_x(1'b1, mk_store(3'b010), 32'd0, 32'h1000_0000, 32'h0000_0001);
        check("stall_rf_we", {31'd0, rf_we}, 32'd0);
        check("stall_wb_val", wb_val, 32'h0000_0104);
        check("stall_dmem_we", {28'd0, dmem_we}, 32'd0);
        tick();
        stall = 1'b0;
        set_x(1'b1, mk_jal(5'd0), 32'h0000_0200, 32'd0, 32'd0);
        check("stall_hold_wa", {27'd0, rf_wa}, 32'd1);
        check("stall_hold_wb", wb_val, 32'h0000_0104);

        // JAL rd=x0
        tick();
        set_x(1'b1, mk_addi(5'd3), 32'd0, 32'h0000_0055, 32'd0);
        check("jal_x0_rf_we", {31'd0, rf_we}, 32'd0);
        check("jal_x0_wb_val", wb_val, 32'h0000_0204);

        // I-ALU result
        tick();
        set_x(1'b1, mk_load(3'b010, 5'd8), 32'd0, 32'h1000_0006, 32'd0);
        check("addi_wb_val", wb_val, 32'h0000_0055);
        check("addi_rf_we", {31'd0, rf_we}, 32'd1);

        // Misaligned LW writes back 0
        tick();
        dmem_dout = 32'hFFFF_FFFF;
        set_x(1'b1, mk_load(3'b010, 5'd9), 32'd0, 32'h6000_0000, 32'd0);
        check("lw_mis_wb_val", wb_val, 32'd0);
        check("lw_mis_pulse", {31'd0, misaligned}, 32'd1);
        check("lw_mis_rf_we", {31'd0, rf_we}, 32'd1);

        // Load from an unmapped region returns 0
        tick();
        set_x(1'b1, mk_store(3'b010), 32'd0, 32'h5000_0000, 32'h0102_0304);
        check("unmapped_wb_val", wb_val, 32'd0);
        check("unmapped_no_fault", {31'd0, misaligned}, 32'd0);
        check("unmapped_st_dmem", {28'd0, dmem_we}, 32'd0);
        check("unmapped_st_imem", {28'd0, imem_wea}, 32'd0);

        // IMEM-only store from a non-BIOS PC
        set_x(1'b1, mk_store(3'b010), 32'h0000_1000, 32'h2000_0000, 32'h1122_3344);
        check("imem_st_dmem_we", {28'd0, dmem_we}, 32'd0);
`ifdef IMEM_WRITE_GUARD_EN
        check("guard_block_wea", {28'd0, imem_wea}, 32'd0);
        tick();
        check("guard_fault_pulse", {31'd0, misaligned}, 32'd1);
        set_x(1'b1, mk_store(3'b010), 32'h4000_0000, 32'h2000_0000, 32'h1122_3344);
        check("guard_bios_wea", {28'd0, imem_wea}, 32'hF);
`else
        check("imem_st_wea", {28'd0, imem_wea}, 32'hF);
        check("imem_st_dina", imem_dina, 32'h1122_3344);
        tick();
        check("imem_st_no_fault", {31'd0, misaligned}, 32'd0);
`endif
        set_x(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("idle_rf_we", {31'd0, rf_we}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
